// File: rtl/max7219_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : max7219_pkg
// Purpose  : Shared constants, FSM encoding and frame builders for the
//            MAX7219 eight-digit display driver.
// Revision : 1.0  initial release
// ============================================================================
package max7219_pkg;

    localparam int FRAME_W     = 16;
    localparam int BIN_W       = 32;
    localparam int BCD_DIGITS  = 10;
    localparam int INIT_FRAMES = 6;

    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;
    localparam logic [3:0] CODEB_BLANK   = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t ST_INIT        = 2'd0;
    localparam state_t ST_IDLE        = 2'd1;
    localparam state_t ST_CONVERT     = 2'd2;
    localparam state_t ST_SEND_DIGITS = 2'd3;

    // Entry 0 is sent first; the intensity data byte is filled in by init_frame.
    localparam logic [INIT_FRAMES-1:0][FRAME_W-1:0] INIT_TABLE = {
        {4'h0, REG_SHUTDOWN,  8'h01},
        {4'h0, REG_SCANLIMIT, 8'h07},
        {4'h0, REG_INTENSITY, 8'h00},
        {4'h0, REG_DECODE,    8'hFF},
        {4'h0, REG_TEST,      8'h00},
        {4'h0, REG_SHUTDOWN,  8'h00}
    };

    function automatic logic [FRAME_W-1:0] init_frame(input logic [2:0] idx,
                                                      input logic [3:0] intensity);
        logic [FRAME_W-1:0] f;
        f = INIT_TABLE[idx];
        if (idx == 3'd3) begin
            f[3:0] = intensity;
        end
        return f;
    endfunction

    // Digit idx (0 = units) goes to register idx+1; it is blanked when it and
    // every more significant shown digit are zero, except the units digit.
    function automatic logic [FRAME_W-1:0] digit_frame(input logic [31:0] bcd,
                                                       input logic [2:0]  idx,
                                                       input logic        blank_en);
        logic [3:0] nib;
        logic       upper_zero;
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j[2:0] == idx) begin
                nib = bcd[4*j +: 4];
            end
            if (j >= int'(idx) && bcd[4*j +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        if (blank_en && idx != 3'd0 && upper_zero) begin
            nib = CODEB_BLANK;
        end
        return {4'h0, {1'b0, idx} + 4'd1, 4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/max7219_display_driver_bin2bcd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble, 32-bit binary to 10 BCD digits,
//            one bit per clock with a start/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import max7219_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    logic [BIN_W-1:0]        bin_q,  bin_d;
    logic [4*BCD_DIGITS-1:0] bcd_q,  bcd_d;
    logic [4:0]              cnt_q,  cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [4*BCD_DIGITS-1:0] w_adj;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? bcd_q[4*g +: 4] + 4'd3
                                                           : bcd_q[4*g +: 4];
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start && !busy_q) begin
            bin_d  = bin;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, bin_d} = {w_adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/max7219_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : max7219_display_driver
// Purpose  : Configures a MAX7219 and shows a 32-bit count in decimal on its
//            eight digits, refreshing whenever the input value changes.
// Revision : 1.0  initial release
// ============================================================================
module max7219_display_driver
    import max7219_pkg::*;
#(
    parameter int         CLK_DIV       = 2,
    parameter logic [3:0] INTENSITY     = 4'h8,
    parameter bit         BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    output logic        max_din,
    output logic        max_clk,
    output logic        max_cs,
    output logic        busy,
    output logic        init_done
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       PH_GAP   = 6'd32;

    state_t        state_q,      state_d;
    logic [2:0]    init_idx_q,   init_idx_d;
    logic [2:0]    dig_idx_q,    dig_idx_d;
    logic          first_q,      first_d;
    logic          init_done_q,  init_done_d;
    logic [31:0]   last_val_q,   last_val_d;
    logic          start_q,      start_d;

    logic                fr_active_q, fr_active_d;
    logic [FRAME_W-1:0]  fr_shift_q,  fr_shift_d;
    logic [5:0]          fr_ph_q,     fr_ph_d;
    logic [DIV_W-1:0]    fr_div_q,    fr_div_d;
    logic                cs_q,        cs_d;
    logic                clk_q,       clk_d;
    logic                din_q,       din_d;

    logic                w_load;
    logic [FRAME_W-1:0]  w_load_data;
    logic                w_div_end;
    logic                w_fr_done;
    logic [5:0]          w_next_ph;
    logic                w_bcd_busy;
    logic                w_bcd_done;
    logic [39:0]         w_bcd;
    logic                w_unused;

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (start_q),
        .bin   (last_val_q),
        .busy  (w_bcd_busy),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    // Digits 9-10 are dropped: the display shows the value modulo 1e8.
    assign w_unused  = &{1'b0, w_bcd_busy, w_bcd[39:32]};

    assign w_div_end = (fr_div_q == DIV_LAST);
    assign w_fr_done = fr_active_q && w_div_end && (fr_ph_q == PH_GAP);
    assign w_next_ph = fr_ph_q + 6'd1;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        dig_idx_d   = dig_idx_q;
        first_d     = first_q;
        init_done_d = init_done_q;
        last_val_d  = last_val_q;
        start_d     = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        case (state_q)
            ST_INIT: begin
                if (!fr_active_q) begin
                    w_load      = 1'b1;
                    w_load_data = init_frame(init_idx_q, INTENSITY);
                end else if (w_fr_done) begin
                    if (init_idx_q == 3'(INIT_FRAMES - 1)) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                        first_d     = 1'b1;
                    end else begin
                        init_idx_d  = init_idx_q + 3'd1;
                        w_load      = 1'b1;
                        w_load_data = init_frame(init_idx_q + 3'd1, INTENSITY);
                    end
                end
            end
            ST_IDLE: begin
                if (first_q || data_in != last_val_q) begin
                    last_val_d = data_in;
                    first_d    = 1'b0;
                    start_d    = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_bcd_done) begin
                    state_d     = ST_SEND_DIGITS;
                    dig_idx_d   = 3'd0;
                    w_load      = 1'b1;
                    w_load_data = digit_frame(w_bcd[31:0], 3'd0, BLANK_LEADING);
                end
            end
            ST_SEND_DIGITS: begin
                if (w_fr_done) begin
                    if (dig_idx_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        dig_idx_d   = dig_idx_q + 3'd1;
                        w_load      = 1'b1;
                        w_load_data = digit_frame(w_bcd[31:0], dig_idx_q + 3'd1, BLANK_LEADING);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Half-phases 0..31 carry the 16 bits (even = SCLK low); phase 32 is the
    // LOAD-high gap. A new frame can start on the edge that ends the gap.
    always_comb begin
        fr_active_d = fr_active_q;
        fr_shift_d  = fr_shift_q;
        fr_ph_d     = fr_ph_q;
        fr_div_d    = fr_div_q;
        cs_d        = cs_q;
        clk_d       = clk_q;
        din_d       = din_q;
        if (w_load) begin
            fr_active_d = 1'b1;
            fr_shift_d  = {w_load_data[FRAME_W-2:0], 1'b0};
            fr_ph_d     = '0;
            fr_div_d    = '0;
            cs_d        = 1'b0;
            clk_d       = 1'b0;
            din_d       = w_load_data[FRAME_W-1];
        end else if (w_fr_done) begin
            fr_active_d = 1'b0;
        end else if (fr_active_q) begin
            if (w_div_end) begin
                fr_div_d = '0;
                fr_ph_d  = w_next_ph;
                if (w_next_ph == PH_GAP) begin
                    clk_d = 1'b0;
                    cs_d  = 1'b1;
                end else begin
                    clk_d = w_next_ph[0];
                    if (!w_next_ph[0]) begin
                        din_d      = fr_shift_q[FRAME_W-1];
                        fr_shift_d = {fr_shift_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                fr_div_d = fr_div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            dig_idx_q   <= '0;
            first_q     <= 1'b0;
            init_done_q <= 1'b0;
            last_val_q  <= '0;
            start_q     <= 1'b0;
            fr_active_q <= 1'b0;
            fr_shift_q  <= '0;
            fr_ph_q     <= '0;
            fr_div_q    <= '0;
            cs_q        <= 1'b1;
            clk_q       <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            dig_idx_q   <= dig_idx_d;
            first_q     <= first_d;
            init_done_q <= init_done_d;
            last_val_q  <= last_val_d;
            start_q     <= start_d;
            fr_active_q <= fr_active_d;
            fr_shift_q  <= fr_shift_d;
            fr_ph_q     <= fr_ph_d;
            fr_div_q    <= fr_div_d;
            cs_q        <= cs_d;
            clk_q       <= clk_d;
            din_q       <= din_d;
        end
    end

    assign max_cs    = cs_q;
    assign max_clk   = clk_q;
    assign max_din   = din_q;
    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_display_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_max7219_display_driver
// Purpose  : Decodes the serial frames of two driver instances and compares
//            them with decimal digits computed arithmetically from the input.
// Revision : 1.0  initial release
// ============================================================================
module tb_max7219_display_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in  = 32'd0;
    logic [31:0] data_in2 = 32'd0;
    logic din1, clk1, cs1, busy1, idone1;
    logic din2, clk2, cs2, busy2, idone2;

    max7219_display_driver #(.CLK_DIV(2), .INTENSITY(4'h8), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in),
        .max_din(din1), .max_clk(clk1), .max_cs(cs1), .busy(busy1), .init_done(idone1));

    max7219_display_driver #(.CLK_DIV(1), .INTENSITY(4'h8), .BLANK_LEADING(1'b0)) dut2 (
        .clock(clock), .reset(reset), .data_in(data_in2),
        .max_din(din2), .max_clk(clk2), .max_cs(cs2), .busy(busy2), .init_done(idone2));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sel    = 1'b0;

    logic [15:0] fq[$];
    int          lowq[$];
    int          fallq[$];
    int          riseq[$];
    logic        idq[$];
    int          phase_tot, phase_bad, clkrise_bad, nb_bad;

    bit          mon_in_frame = 1'b0;
    int          mon_nb = 0;
    bit          mon_pcs = 1'b1;
    bit          mon_pclk = 1'b0;
    int          mon_run = 0;
    int          mon_low = 0;
    logic [15:0] mon_sh = '0;
    logic        m_cs, m_clk, m_din, m_id;
    int          m_cd;

    logic [15:0] init_exp [6] = '{16'h0C00, 16'h0F00, 16'h09FF, 16'h0A08, 16'h0B07, 16'h0C01};

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    // Frame decoder: samples on the falling system-clock edge.
    initial begin
        forever begin
            @(negedge clock);
            m_cs  = sel ? cs2 : cs1;
            m_clk = sel ? clk2 : clk1;
            m_din = sel ? din2 : din1;
            m_id  = sel ? idone2 : idone1;
            m_cd  = sel ? 1 : 2;
            if (reset) begin
                mon_in_frame = 1'b0;
                m_cs = 1'b1;
                m_clk = 1'b0;
            end else if (mon_pcs && !m_cs) begin
                mon_in_frame = 1'b1;
                mon_run = 1; mon_low = 1; mon_nb = 0; mon_sh = '0;
                fallq.push_back(cyc);
                idq.push_back(m_id);
            end else if (mon_in_frame && !m_cs) begin
                mon_low++;
                if (m_clk == mon_pclk) mon_run++;
                else begin
                    phase_tot++;
                    if (mon_run != m_cd) phase_bad++;
                    mon_run = 1;
                    if (m_clk) begin mon_sh = {mon_sh[14:0], m_din}; mon_nb++; end
                end
            end else if (mon_in_frame && m_cs) begin
                phase_tot++;
                if (mon_run != m_cd) phase_bad++;
                if (m_clk) clkrise_bad++;
                if (mon_nb != 16) nb_bad++;
                fq.push_back(mon_sh);
                lowq.push_back(mon_low);
                riseq.push_back(cyc);
                mon_in_frame = 1'b0;
            end
            mon_pcs  = m_cs;
            mon_pclk = m_clk;
        end
    end

    function automatic logic [15:0] exp_digit(input logic [31:0] val, input int k, input bit blank);
        longint v, p;
        int d;
        logic [3:0] nib;
        v = {32'd0, val};
        v = v % 64'd100000000;
        p = 1;
        for (int i = 1; i < k; i++) p = p * 10;
        d = int'((v / p) % 10);
        nib = (blank && k >= 2 && v < p) ? 4'hF : 4'(d);
        return {4'h0, 4'(k), 4'h0, nib};
    endfunction

    function automatic logic [15:0] qget(input int i);
        if (i < fq.size()) return fq[i];
        return 16'hxxxx;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_mon();
        fq.delete(); lowq.delete(); fallq.delete(); riseq.delete(); idq.delete();
        phase_tot = 0; phase_bad = 0; clkrise_bad = 0; nb_bad = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (i < budget && !ok) begin
            if (fq.size() >= n) ok = 1'b1;
            else begin tick(); i++; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (i < budget && !ok) begin
            if ((sel ? busy2 : busy1) == 1'b0) ok = 1'b1;
            else begin tick(); i++; end
        end
    endtask

    task automatic do_update(input logic [31:0] v, output int set_cyc, output bit ok);
        bit ok_idle;
        wait_idle(3000, ok_idle);
        clear_mon();
        if (sel) data_in2 = v; else data_in = v;
        set_cyc = cyc;
        wait_frames(8, 3000, ok);
        ok = ok && ok_idle;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (cs1 !== 1'b1)    begin errors++; $display("FAIL reset_cs: got %b expected 1", cs1); end
        checks++; if (clk1 !== 1'b0)   begin errors++; $display("FAIL reset_clk: got %b expected 0", clk1); end
        checks++; if (din1 !== 1'b0)   begin errors++; $display("FAIL reset_din: got %b expected 0", din1); end
        checks++; if (busy1 !== 1'b1)  begin errors++; $display("FAIL reset_busy: got %b expected 1", busy1); end
        checks++; if (idone1 !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", idone1); end
        clear_mon();
        reset = 1'b0;
    endtask

    task automatic test_init();
        bit ok;
        wait_frames(14, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL init_timeout: got %0d frames expected 14", fq.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (qget(i) !== init_exp[i]) begin errors++; $display("FAIL init_frame%0d: got %h expected %h", i, qget(i), init_exp[i]); end
        end
        checks++;
        if (idq.size() < 7 || idq[5] !== 1'b0 || idq[6] !== 1'b1) begin
            errors++; $display("FAIL init_done_timing: got size %0d expected low for frame 6 and high for frame 7", idq.size());
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(5 + k) !== exp_digit(32'd0, k, 1'b1)) begin
                errors++; $display("FAIL init_refresh_d%0d: got %h expected %h", k, qget(5 + k), exp_digit(32'd0, k, 1'b1));
            end
        end
        wait_idle(500, ok);
        checks++; if (busy1 !== 1'b0 || !ok) begin errors++; $display("FAIL init_busy_drop: got %b expected 0", busy1); end
        checks++; if (idone1 !== 1'b1) begin errors++; $display("FAIL init_done_level: got %b expected 1", idone1); end
    endtask

    task automatic test_1234();
        bit ok;
        int sc, bad_low, bad_per, lat;
        do_update(32'd1234, sc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL u1234_timeout: got %0d frames expected 8", fq.size()); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(k - 1) !== exp_digit(32'd1234, k, 1'b1)) begin
                errors++; $display("FAIL u1234_d%0d: got %h expected %h", k, qget(k - 1), exp_digit(32'd1234, k, 1'b1));
            end
        end
        bad_low = 0; bad_per = 0;
        foreach (lowq[i]) if (lowq[i] != 64) bad_low++;
        for (int i = 0; i + 1 < fallq.size(); i++) if (fallq[i+1] - fallq[i] != 66) bad_per++;
        checks++; if (bad_low != 0 || lowq.size() != 8) begin errors++; $display("FAIL u1234_cs_low: got %0d bad of %0d expected 0 bad (64 cycles)", bad_low, lowq.size()); end
        checks++; if (bad_per != 0) begin errors++; $display("FAIL u1234_period: got %0d bad periods expected 0 (66 cycles)", bad_per); end
        checks++; if (phase_bad != 0 || phase_tot != 256) begin errors++; $display("FAIL u1234_sclk_phase: got %0d bad of %0d expected 0 of 256", phase_bad, phase_tot); end
        checks++; if (nb_bad != 0 || clkrise_bad != 0) begin errors++; $display("FAIL u1234_bits: got nb_bad %0d clk_at_load %0d expected 0", nb_bad, clkrise_bad); end
        lat = (riseq.size() > 0) ? riseq[riseq.size()-1] - (sc + 1) : -1;
        checks++; if (lat != 1 + 33 + 8*33*2 - 2) begin errors++; $display("FAIL u1234_latency: got %0d expected %0d", lat, 1 + 33 + 8*33*2 - 2); end
    endtask

    task automatic test_max();
        bit ok;
        int sc;
        do_update(32'hFFFF_FFFF, sc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL umax_timeout: got %0d frames expected 8", fq.size()); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(k - 1) !== exp_digit(32'hFFFF_FFFF, k, 1'b1)) begin
                errors++; $display("FAIL umax_d%0d: got %h expected %h", k, qget(k - 1), exp_digit(32'hFFFF_FFFF, k, 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_idle(3000, ok);
        clear_mon();
        data_in = 32'd5;
        wait_frames(2, 3000, ok);
        data_in = 32'd6;
        repeat (20) tick();
        data_in = 32'd7;
        wait_frames(16, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d frames expected 16", fq.size()); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(k - 1) !== exp_digit(32'd5, k, 1'b1)) begin errors++; $display("FAIL b2b_first_d%0d: got %h expected %h", k, qget(k - 1), exp_digit(32'd5, k, 1'b1)); end
            checks++;
            if (qget(k + 7) !== exp_digit(32'd7, k, 1'b1)) begin errors++; $display("FAIL b2b_second_d%0d: got %h expected %h", k, qget(k + 7), exp_digit(32'd7, k, 1'b1)); end
        end
        repeat (700) tick();
        checks++; if (fq.size() != 16) begin errors++; $display("FAIL b2b_hold_frames: got %0d frames expected 16", fq.size()); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_hold_busy: got %b expected 0", busy1); end
    endtask

    task automatic test_random();
        bit ok;
        int sc;
        logic [31:0] v;
        for (int n = 0; n < 6; n++) begin
            v = (n % 2 == 0) ? 32'($urandom_range(0, 99999)) : 32'($urandom);
            if (v == data_in) v = v + 32'd1;
            do_update(v, sc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout: got %0d frames expected 8", n, fq.size()); end
            for (int k = 1; k <= 8; k++) begin
                checks++;
                if (qget(k - 1) !== exp_digit(v, k, 1'b1)) begin
                    errors++; $display("FAIL rnd%0d_d%0d (value %0d): got %h expected %h", n, k, v, qget(k - 1), exp_digit(v, k, 1'b1));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int i;
        wait_idle(3000, ok);
        clear_mon();
        data_in = 32'd12345678;
        ok = 1'b0; i = 0;
        while (i < 3000 && !ok) begin
            if (fq.size() == 2 && mon_in_frame && mon_nb >= 8) ok = 1'b1;
            else begin tick(); i++; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_reach_bit8: got %0d frames expected to reach digit 3 bit 8", fq.size()); end
        #1 reset = 1'b1;
        #1;
        checks++; if (cs1 !== 1'b1)    begin errors++; $display("FAIL rmid_cs: got %b expected 1", cs1); end
        checks++; if (clk1 !== 1'b0)   begin errors++; $display("FAIL rmid_clk: got %b expected 0", clk1); end
        checks++; if (idone1 !== 1'b0) begin errors++; $display("FAIL rmid_init_done: got %b expected 0", idone1); end
        repeat (3) tick();
        clear_mon();
        reset = 1'b0;
        wait_frames(14, 4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got %0d frames expected 14", fq.size()); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (qget(j) !== init_exp[j]) begin errors++; $display("FAIL rmid_init%0d: got %h expected %h", j, qget(j), init_exp[j]); end
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(5 + k) !== exp_digit(32'd12345678, k, 1'b1)) begin
                errors++; $display("FAIL rmid_refresh_d%0d: got %h expected %h", k, qget(5 + k), exp_digit(32'd12345678, k, 1'b1));
            end
        end
    endtask

    task automatic test_div1();
        bit ok;
        int sc, bad_low, bad_per, lat;
        sel = 1'b1;
        do_update(32'd7, sc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL div1_timeout: got %0d frames expected 8", fq.size()); end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (qget(k - 1) !== exp_digit(32'd7, k, 1'b0)) begin
                errors++; $display("FAIL div1_d%0d: got %h expected %h", k, qget(k - 1), exp_digit(32'd7, k, 1'b0));
            end
        end
        bad_low = 0; bad_per = 0;
        foreach (lowq[i]) if (lowq[i] != 32) bad_low++;
        for (int i = 0; i + 1 < fallq.size(); i++) if (fallq[i+1] - fallq[i] != 33) bad_per++;
        checks++; if (bad_low != 0 || lowq.size() != 8) begin errors++; $display("FAIL div1_cs_low: got %0d bad of %0d expected 0 bad (32 cycles)", bad_low, lowq.size()); end
        checks++; if (bad_per != 0) begin errors++; $display("FAIL div1_period: got %0d bad periods expected 0 (33 cycles)", bad_per); end
        checks++; if (phase_bad != 0 || phase_tot != 256) begin errors++; $display("FAIL div1_sclk_phase: got %0d bad of %0d expected 0 of 256", phase_bad, phase_tot); end
        lat = (riseq.size() > 0) ? riseq[riseq.size()-1] - (sc + 1) : -1;
        checks++; if (lat != 1 + 33 + 8*33 - 1) begin errors++; $display("FAIL div1_latency: got %0d expected %0d", lat, 1 + 33 + 8*33 - 1); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init();
        test_1234();
        test_max();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
